// File: rtl/sat_alu_pkg.sv
// Shared types and constants for the saturating ALU scheduler.
package sat_alu_pkg;

    localparam int DATA_W = 14;
    localparam int FRAC_W = 11;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [DATA_W-1:0] SAT_POS = 14'h1FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 14'h2000;

endpackage

// File: rtl/sat_alu_core.sv
// Combinational 14-bit saturating add/sub/mult/pass unit (Q2.11 multiply).
module sat_alu_core
    import sat_alu_pkg::*;
(
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              sat
);

    // Result packed as {clamped, value}; overflow judged from operand and raw sign bits.
    function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] y,
                                                input logic                     cin);
        logic signed [DATA_W-1:0] raw;
        raw = x + y + $signed({{(DATA_W-1){1'b0}}, cin});
        if (!x[DATA_W-1] && !y[DATA_W-1] && raw[DATA_W-1])
            return {1'b1, SAT_POS};
        if (x[DATA_W-1] && y[DATA_W-1] && !raw[DATA_W-1])
            return {1'b1, SAT_NEG};
        return {1'b0, raw};
    endfunction

    // Guard bits above the Q2.11 window must all match the window's sign bit.
    function automatic logic [DATA_W:0] sat_mul(input logic signed [DATA_W-1:0] x,
                                                input logic signed [DATA_W-1:0] y);
        logic signed [2*DATA_W-1:0] p;
        logic [2*DATA_W-FRAC_W-DATA_W:0] guard;
        p     = x * y;
        guard = p[2*DATA_W-1:DATA_W+FRAC_W-1];
        if ((&guard) || !(|guard))
            return {1'b0, p[DATA_W+FRAC_W-1:FRAC_W]};
        return {1'b1, p[2*DATA_W-1] ? SAT_NEG : SAT_POS};
    endfunction

    logic [DATA_W:0] r;

    always_comb begin
        r = '0;
        case (op_e'(op))
            OP_ADD:  r = sat_add(a, b, 1'b0);
            OP_SUB:  r = sat_add(a, ~b, 1'b1);
            OP_MUL:  r = sat_mul(a, b);
            default: r = {1'b0, a};
        endcase
    end

    assign sat = r[DATA_W];
    assign res = r[DATA_W-1:0];

endmodule

// File: rtl/sat_alu_sched.sv
// Round-robin scheduler for the shared saturating ALU with valid/ready result return.
// Optional saturation event counter enabled by defining SAT_STAT_EN.
module sat_alu_sched
    import sat_alu_pkg::*;
#(
    parameter int MULT_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [13:0] a0,
    input  logic [13:0] b0,
    input  logic [13:0] a1,
    input  logic [13:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [13:0] res,
    output logic        res_vld,
    output logic        res_id,
    output logic        res_sat,
    input  logic        res_rdy,
    output logic        busy,
    output logic [7:0]  sat_cnt
);

    localparam logic [3:0] CNT_MUL = 4'(MULT_CYC - 1);

    state_e state_q, state_d;
    logic   ptr_q;
    logic   [3:0] cnt_q;
    logic   grant, win, done;
    logic   [1:0] op_sel;

    logic   [1:0]        op_p0;
    logic   [DATA_W-1:0] a_p0, b_p0;
    logic                id_p0;

    logic   [DATA_W-1:0] core_res;
    logic                core_sat;

    logic   [DATA_W-1:0] res_p1;
    logic                sat_p1, id_p1, vld_p1;

    assign op_sel = win ? op1 : op0;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    win     = (req0 && req1) ? ptr_q : req1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    done    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_rdy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            res_p1  <= '0;
            sat_p1  <= 1'b0;
            id_p1   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0    <= grant && !win;
            gnt1    <= grant && win;
            if (grant) begin
                ptr_q <= ~win;
                cnt_q <= (op_e'(op_sel) == OP_MUL) ? CNT_MUL : 4'd0;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done) begin
                res_p1 <= core_res;
                sat_p1 <= core_sat;
                id_p1  <= id_p0;
            end
        end
    end

    // Stage p0: operand capture on the granting edge
    always_ff @(posedge clk) begin
        if (grant) begin
            op_p0 <= op_sel;
            a_p0  <= win ? a1 : a0;
            b_p0  <= win ? b1 : b0;
            id_p0 <= win;
        end
    end

    sat_alu_core u_core (
        .op  (op_p0),
        .a   (a_p0),
        .b   (b_p0),
        .res (core_res),
        .sat (core_sat)
    );

    // Stage p1: registered result, valid while waiting in RESP
    assign vld_p1  = (state_q == RESP);
    assign res     = res_p1;
    assign res_sat = sat_p1;
    assign res_id  = id_p1;
    assign res_vld = vld_p1;
    assign busy    = (state_q != IDLE);

`ifdef SAT_STAT_EN
    logic [7:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt_q <= 8'h00;
        else if (vld_p1 && res_rdy && sat_p1 && sat_cnt_q != 8'hFF)
            sat_cnt_q <= sat_cnt_q + 8'h01;
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sat_alu_sched.sv
// Bench for sat_alu_sched: directed vector table, hand sequences and randomized model checks.
module tb_sat_alu_sched;

    localparam int MULT_CYC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [13:0] a0, b0, a1, b1;
    logic        gnt0, gnt1;
    logic [13:0] res;
    logic        res_vld, res_id, res_sat;
    logic        res_rdy;
    logic        busy;
    logic [7:0]  sat_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    sat_alu_sched #(.MULT_CYC(MULT_CYC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .op0     (op0),
        .op1     (op1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .res     (res),
        .res_vld (res_vld),
        .res_id  (res_id),
        .res_sat (res_sat),
        .res_rdy (res_rdy),
        .busy    (busy),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          id;
        logic [1:0]  op;
        logic [13:0] a;
        logic [13:0] b;
        logic [13:0] er;
        bit          es;
        int          hold;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_sat_cnt();
`ifdef SAT_STAT_EN
        return (exp_cnt > 255) ? 255 : exp_cnt;
`else
        return 0;
`endif
    endfunction

    // Reference: exact arithmetic on signed integers, then clamp to the 14-bit range.
    function automatic void model(input logic [1:0] op, input logic [13:0] a, input logic [13:0] b,
                                  output logic [13:0] r, output bit s);
        longint sa, sb, v;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    v = sa + sb;
            2'd1:    v = sa - sb;
            2'd2:    v = (sa * sb) >>> 11;
            default: v = sa;
        endcase
        if (v > 8191) begin
            r = 14'h1FFF; s = 1'b1;
        end else if (v < -8192) begin
            r = 14'h2000; s = 1'b1;
        end else begin
            r = v[13:0]; s = 1'b0;
        end
    endfunction

    task automatic check_zero(input string nm);
        chk({nm, " gnt0"}, gnt0, 0);
        chk({nm, " gnt1"}, gnt1, 0);
        chk({nm, " res"}, res, 0);
        chk({nm, " res_vld"}, res_vld, 0);
        chk({nm, " res_id"}, res_id, 0);
        chk({nm, " res_sat"}, res_sat, 0);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " sat_cnt"}, sat_cnt, 0);
    endtask

    // One full transaction from the current negedge: request, grant, latency, hold, accept.
    task automatic txn(input bit id, input logic [1:0] op, input logic [13:0] a, input logic [13:0] b,
                       input logic [13:0] er, input bit es, input int hold, input string nm);
        int n;
        int lat;
        if (id) begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end
        res_rdy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((id ? gnt1 : gnt0) !== 1'b1) && n < 50);
        chk({nm, " gnt"}, id ? gnt1 : gnt0, 1);
        chk({nm, " other gnt"}, id ? gnt0 : gnt1, 0);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        lat = 1;
        chk({nm, " gnt one cycle"}, id ? gnt1 : gnt0, 0);
        while (res_vld !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, (op == 2'd2) ? MULT_CYC : 1);
        chk({nm, " res"}, res, er);
        chk({nm, " res_sat"}, res_sat, es);
        chk({nm, " res_id"}, res_id, id);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " held vld"}, res_vld, 1);
            chk({nm, " held res"}, {res_id, res_sat, res}, {id, es, er});
        end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk({nm, " vld drop"}, res_vld, 0);
        if (es) exp_cnt++;
        chk({nm, " sat_cnt"}, sat_cnt, exp_sat_cnt());
    endtask

    initial begin
        vec_t tbl[12];
        int   gq[$];
        int   rq[$];
        int   n;
        logic [13:0] er, hr;
        bit   es, hs;
        logic [13:0] pool[6];

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_rdy = 1'b0;
        op0 = 2'd0; op1 = 2'd0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        tbl[0]  = '{0, 2'd0, 14'h1000, 14'h1000, 14'h1FFF, 1, 0};
        tbl[1]  = '{0, 2'd1, 14'h2000, 14'h0001, 14'h2000, 1, 0};
        tbl[2]  = '{0, 2'd1, 14'h0005, 14'h0003, 14'h0002, 0, 0};
        tbl[3]  = '{0, 2'd3, 14'h2ABC, 14'h1234, 14'h2ABC, 0, 0};
        tbl[4]  = '{0, 2'd2, 14'h0800, 14'h0800, 14'h0800, 0, 0};
        tbl[5]  = '{0, 2'd2, 14'h1000, 14'h1000, 14'h1FFF, 1, 0};
        tbl[6]  = '{0, 2'd2, 14'h1000, 14'h3000, 14'h2000, 0, 0};
        tbl[7]  = '{1, 2'd0, 14'h2000, 14'h3FFF, 14'h2000, 1, 0};
        tbl[8]  = '{1, 2'd0, 14'h1FFF, 14'h0000, 14'h1FFF, 0, 1};
        tbl[9]  = '{1, 2'd1, 14'h0000, 14'h2000, 14'h1FFF, 1, 0};
        tbl[10] = '{1, 2'd2, 14'h3800, 14'h0800, 14'h3800, 0, 2};
        tbl[11] = '{0, 2'd0, 14'h0003, 14'h3FFE, 14'h0001, 0, 5};

        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        exp_cnt = 0;

        for (int i = 0; i < 12; i++)
            txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].er, tbl[i].es, tbl[i].hold,
                $sformatf("vec%0d", i));

        // Back-pressure with a competing request pending during RESP
        req0 = 1'b1; op0 = 2'd0; a0 = 14'h0100; b0 = 14'h0200;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt0 !== 1'b1 && n < 50);
        chk("bp gnt0", gnt0, 1);
        req0 = 1'b0;
        n = 0;
        while (res_vld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("bp res", res, 14'h0300);
        req1 = 1'b1; op1 = 2'd1; a1 = 14'h0010; b1 = 14'h0020;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp held", {res_vld, res_id, res_sat, res}, {1'b1, 1'b0, 1'b0, 14'h0300});
            chk("bp no gnt1", gnt1, 0);
        end
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
        chk("bp accepted", res_vld, 0);
        chk("bp gnt1 not yet", gnt1, 0);
        @(negedge clk);
        chk("bp gnt1 next", gnt1, 1);
        req1 = 1'b0;
        res_rdy = 1'b1;
        n = 0;
        while (res_vld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("bp second res", {res_id, res_sat, res}, {1'b1, 1'b0, 14'h3FF0});
        @(negedge clk);
        res_rdy = 1'b0;

        // Arbitration: both requesters held high after reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        req0 = 1'b1; op0 = 2'd0; a0 = 14'h0001; b0 = 14'h0001;
        req1 = 1'b1; op1 = 2'd1; a1 = 14'h0007; b1 = 14'h0002;
        res_rdy = 1'b1;
        n = 0;
        while ((gq.size() < 4 || rq.size() < 4 || busy !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt0 === 1'b1) gq.push_back(0);
            if (gnt1 === 1'b1) gq.push_back(1);
            if (gq.size() >= 4) begin req0 = 1'b0; req1 = 1'b0; end
            if (res_vld === 1'b1) begin
                rq.push_back(int'(res_id));
                chk("arb res", res, res_id ? 14'h0005 : 14'h0002);
            end
        end
        res_rdy = 1'b0;
        chk("arb grant count", gq.size(), 4);
        chk("arb result count", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("arb gnt order %0d", i), (i < gq.size()) ? gq[i] : 9, i % 2);
            chk($sformatf("arb res_id order %0d", i), (i < rq.size()) ? rq[i] : 9, i % 2);
        end

        // Reset during the second multiply cycle drops the operation
        req0 = 1'b1; op0 = 2'd2; a0 = 14'h0800; b0 = 14'h0800;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt0 !== 1'b1 && n < 50);
        chk("rst gnt0", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        chk("rst exec busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check_zero("mid-mult reset");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post reset quiet", {gnt0, gnt1, res_vld, busy}, 4'b0000);
        end

        // Randomized operations against the reference model
        pool = '{14'h1FFF, 14'h2000, 14'h0000, 14'h3FFF, 14'h1000, 14'h3000};
        for (int i = 0; i < 150; i++) begin
            bit          rid;
            logic [1:0]  rop;
            logic [13:0] ra, rb;
            rid = 1'($urandom_range(0, 1));
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 14'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 14'($urandom);
            model(rop, ra, rb, er, es);
            txn(rid, rop, ra, rb, er, es, $urandom_range(0, 2), $sformatf("rand%0d", i));
        end

        // Long run of saturating results exercises the counter ceiling
        model(2'd0, 14'h1000, 14'h1000, hr, hs);
        for (int i = 0; i < 300; i++)
            txn(i[0], 2'd0, 14'h1000, 14'h1000, hr, hs, 0, "satrun");
        chk("sat_cnt final", sat_cnt, exp_sat_cnt());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
